// File: rtl/ahb_axi_pkg.sv
// Shared constants, FSM state type and strobe/error helpers
// for the AHB-Lite to AXI4 bridge.
package ahb_axi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCAP,
    ST_WISS,
    ST_WRSP,
    ST_RISS,
    ST_RDAT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] strb_gen(
    input logic [2:0] size,
    input logic [1:0] addr
  );
    logic [3:0] s;
    s = 4'h0;
    unique case (1'b1)
      (size == 3'd0): s = 4'b0001 << addr;
      (size == 3'd1): s = 4'b0011 << {addr[1], 1'b0};
      default:        s = 4'hF;
    endcase
    return s;
  endfunction

  function automatic logic xfer_bad(
    input logic [2:0] size,
    input logic [1:0] addr
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (size > 3'd2):  bad = 1'b1;
      (size == 3'd2): bad = |addr;
      (size == 3'd1): bad = addr[0];
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb2axi_bridge_if.sv
// AHB-Lite slave port plus AXI4 master port of the bridge.
// slave = bridge view, master = surrounding system view.
interface ahb2axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport slave (
    input  hsel, haddr, htrans, hwrite,
    input  hsize, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output awvalid, awaddr, awid, awlen,
    output awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen,
    output arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport master (
    output hsel, haddr, htrans, hwrite,
    output hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  awvalid, awaddr, awid, awlen,
    input  awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen,
    input  arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ahb2axi_bridge.sv
// AHB-Lite slave to AXI4 master bridge: every AHB beat becomes
// one single-beat AXI transaction, AHB stalled until it finishes.
module ahb2axi_bridge
  import ahb_axi_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input logic aclk,
  input logic aresetn,
  ahb2axi_bridge_if.slave bus
);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [3:0]        strb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              aw_done;
  logic              w_done;
  logic              take;
  logic              aw_hs;
  logic              w_hs;
  logic              bad;
  logic              unused;

  assign take  = bus.hsel & bus.hready
               & bus.htrans[1]
               & (state == ST_IDLE);
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign bad   = xfer_bad(bus.hsize, bus.haddr[1:0]);

  assign unused = ^{bus.bid, bus.rid, bus.rlast,
                    bus.bresp[0], bus.rresp[0],
                    bus.htrans[0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (take)
          nxt = bad        ? ST_ERR1 :
                bus.hwrite ? ST_WCAP : ST_RISS;
      ST_WCAP: nxt = ST_WISS;
      ST_WISS:
        if ((aw_done | aw_hs) & (w_done | w_hs))
          nxt = ST_WRSP;
      ST_WRSP:
        if (bus.bvalid)
          nxt = bus.bresp[1] ? ST_ERR1 : ST_IDLE;
      ST_RISS:
        if (bus.arready) nxt = ST_RDAT;
      ST_RDAT:
        if (bus.rvalid)
          nxt = bus.rresp[1] ? ST_ERR1 : ST_IDLE;
      ST_ERR1: nxt = ST_ERR2;
      ST_ERR2: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      size_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (take) begin
        addr_q <= bus.haddr;
        size_q <= bus.hsize;
        strb_q <= strb_gen(bus.hsize, bus.haddr[1:0]);
      end
      if (state == ST_WCAP)
        wdata_q <= bus.hwdata;
      if (state == ST_RDAT && bus.rvalid)
        rdata_q <= bus.rdata;
      // AW and W complete independently; remember each.
      if (state == ST_WISS) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.hreadyout = (state == ST_IDLE)
                  | (state == ST_ERR2);
    bus.hresp     = (state == ST_ERR1)
                  | (state == ST_ERR2);
    bus.hrdata    = rdata_q;
    bus.awvalid   = (state == ST_WISS) & ~aw_done;
    bus.wvalid    = (state == ST_WISS) & ~w_done;
    bus.bready    = (state == ST_WRSP);
    bus.arvalid   = (state == ST_RISS);
    bus.rready    = (state == ST_RDAT);
    bus.awaddr    = addr_q;
    bus.araddr    = addr_q;
    bus.awsize    = size_q;
    bus.arsize    = size_q;
    bus.awid      = AXI_ID;
    bus.arid      = AXI_ID;
    bus.awlen     = 8'd0;
    bus.arlen     = 8'd0;
    bus.awburst   = AXI_BURST_INCR;
    bus.arburst   = AXI_BURST_INCR;
    bus.wdata     = wdata_q;
    bus.wstrb     = strb_q;
    bus.wlast     = 1'b1;
  end

endmodule

// File: tb/tb_ahb2axi_bridge.sv
// Randomized scoreboard bench for ahb2axi_bridge with a
// configurable-latency AXI target model.
module tb_ahb2axi_bridge;
  import ahb_axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ahb2axi_bridge_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus();

  ahb2axi_bridge #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(4'h0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );

  assign bus.hready = bus.hreadyout;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } a_exp_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_exp_t;
  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } r_exp_t;

  a_exp_t aw_q[$];
  a_exp_t ar_q[$];
  w_exp_t w_q[$];
  r_exp_t rsp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // target behaviour for the transaction in flight
  int daw = 0, dw = 0, db = 0, dar = 0, dr = 0;
  logic [1:0]  bresp_v = 2'b00;
  logic [1:0]  rresp_v = 2'b00;
  logic [31:0] rdata_v = 32'h0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic logic [3:0] ref_strb(
    input logic [2:0] size, input logic [1:0] a);
    int nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << a);
  endfunction

  function automatic logic ref_bad(
    input logic [2:0] size, input logic [1:0] a);
    int nb;
    nb = 1 << size;
    return (size > 3'd2) || ((int'(a) % nb) != 0);
  endfunction

  // AXI target: readies/valids follow the planned delays
  int acnt = 0, wcnt = 0, bcnt = 0, rcnt = 0, arcnt = 0;
  always @(posedge aclk) begin
    #2;
    if (bus.awvalid) begin
      bus.awready = (acnt >= daw); acnt++;
    end else begin
      bus.awready = 1'b0; acnt = 0;
    end
    if (bus.wvalid) begin
      bus.wready = (wcnt >= dw); wcnt++;
    end else begin
      bus.wready = 1'b0; wcnt = 0;
    end
    if (bus.arvalid) begin
      bus.arready = (arcnt >= dar); arcnt++;
    end else begin
      bus.arready = 1'b0; arcnt = 0;
    end
    if (bus.bready) begin
      bus.bvalid = (bcnt >= db); bcnt++;
      bus.bresp  = bus.bvalid ? bresp_v : 2'b00;
    end else begin
      bus.bvalid = 1'b0; bcnt = 0;
    end
    if (bus.rready) begin
      bus.rvalid = (rcnt >= dr); rcnt++;
      bus.rdata  = bus.rvalid ? rdata_v : $urandom;
      bus.rresp  = bus.rvalid ? rresp_v : 2'b00;
    end else begin
      bus.rvalid = 1'b0; rcnt = 0;
    end
  end

  // channel monitors
  logic awv_wait = 0, wv_wait = 0, arv_wait = 0;
  always @(negedge aclk) begin
    a_exp_t a;
    w_exp_t w;
    if (!aresetn) begin
      awv_wait = 0; wv_wait = 0; arv_wait = 0;
    end else begin
      if (awv_wait) chk("awvalid_hold", 32'(bus.awvalid), 1);
      if (wv_wait)  chk("wvalid_hold", 32'(bus.wvalid), 1);
      if (arv_wait) chk("arvalid_hold", 32'(bus.arvalid), 1);
      if (bus.awvalid && bus.awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          a = aw_q.pop_front();
          chk("awaddr", bus.awaddr, a.addr);
          chk("awsize", 32'(bus.awsize), 32'(a.size));
          chk("awlen_burst_id",
              {20'h0, bus.awlen, bus.awburst, bus.awid[1:0]},
              {20'h0, 8'd0, AXI_BURST_INCR, 2'd0});
        end
      end
      if (bus.wvalid && bus.wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          w = w_q.pop_front();
          chk("wdata", bus.wdata, w.data);
          chk("wstrb_wlast", {27'h0, bus.wlast, bus.wstrb},
              {27'h0, 1'b1, w.strb});
        end
      end
      if (bus.arvalid && bus.arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          a = ar_q.pop_front();
          chk("araddr", bus.araddr, a.addr);
          chk("arsize_len", {21'h0, bus.arlen, bus.arsize},
              {21'h0, 8'd0, a.size});
        end
      end
      awv_wait = bus.awvalid && !bus.awready;
      wv_wait  = bus.wvalid && !bus.wready;
      arv_wait = bus.arvalid && !bus.arready;
    end
  end

  // AHB completion monitor
  logic pend = 0;
  logic prev_hresp = 0;
  int   cyc = 0;
  always @(negedge aclk) begin
    r_exp_t r;
    if (!aresetn) begin
      pend = 0;
      prev_hresp = 0;
    end else begin
      if (pend) begin
        cyc++;
        if (bus.hreadyout) begin
          pend = 0;
          if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            r = rsp_q.pop_front();
            chk("hresp", 32'(bus.hresp), 32'(r.err));
            chk("hresp_first_cycle", 32'(prev_hresp), 32'(r.err));
            if (r.rd && !r.err) chk("hrdata", bus.hrdata, r.rdata);
            if (r.lat >= 0) chk("latency", cyc, r.lat);
          end
        end
      end else if (bus.hsel && bus.hready &&
                   bus.htrans[1] && bus.hreadyout) begin
        pend = 1;
        cyc = 0;
      end
      prev_hresp = bus.hresp;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!bus.hreadyout && n < 200);
    if (!bus.hreadyout) chk("done_timeout", 32'(bus.hreadyout), 1);
    @(posedge aclk); #1;
    chk("aw_w_ar_left", aw_q.size() + w_q.size() + ar_q.size(), 0);
  endtask

  // one AHB beat; d1 = AW/AR delay, d2 = W delay, d3 = B/R delay
  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [2:0] size,
                      input logic [31:0] data,
                      input logic [1:0] resp,
                      input int d1, input int d2, input int d3,
                      input bit wait_rsp);
    r_exp_t r;
    logic   bad;
    int     mx;
    bad = ref_bad(size, addr[1:0]);
    daw = d1; dar = d1; dw = d2; db = d3; dr = d3;
    bresp_v = resp; rresp_v = resp; rdata_v = data;
    if (!bad) begin
      if (wr) begin
        aw_q.push_back('{addr, size});
        w_q.push_back('{data, ref_strb(size, addr[1:0])});
      end else begin
        ar_q.push_back('{addr, size});
      end
    end
    mx = (d1 > d2) ? d1 : d2;
    r.rd = !wr;
    r.err = bad || resp[1];
    r.rdata = data;
    if (bad)     r.lat = 2;
    else if (wr) r.lat = 4 + mx + d3 + int'(resp[1]);
    else         r.lat = 3 + d1 + d3 + int'(resp[1]);
    if (wait_rsp) rsp_q.push_back(r);
    bus.hsel = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.haddr = addr;
    bus.hwrite = wr;
    bus.hsize = size;
    @(posedge aclk); #1;
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = wr ? data : 32'h0;
    if (wait_rsp) wait_done();
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    logic [1:0]  rs;
    int          k;
    bus.hsel = 0; bus.haddr = 0; bus.htrans = 0;
    bus.hwrite = 0; bus.hsize = 0; bus.hwdata = 0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.rlast = 1; bus.rid = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_hreadyout", 32'(bus.hreadyout), 1);
    chk("rst_hresp", 32'(bus.hresp), 0);
    chk("rst_hrdata", bus.hrdata, 0);
    chk("rst_valids", {27'h0, bus.awvalid, bus.wvalid,
        bus.arvalid, bus.bready, bus.rready}, 0);
    chk("rst_addr", bus.awaddr | bus.araddr, 0);
    chk("rst_wdata_wstrb", bus.wdata | 32'(bus.wstrb), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    xfer(1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 1);
    xfer(1, 32'h1000_0003, 3'd0, 32'hAA00_0000, 2'b00, 0, 0, 0, 1);
    xfer(1, 32'h1000_0002, 3'd1, 32'h5566_0000, 2'b00, 0, 0, 0, 1);
    xfer(0, 32'h2000_0000, 3'd2, 32'h1234_5678, 2'b00, 0, 0, 5, 1);
    xfer(1, 32'h3000_0008, 3'd2, 32'h0BAD_F00D, 2'b00, 3, 0, 0, 1);
    xfer(1, 32'h3000_000C, 3'd2, 32'hC0FF_EE00, 2'b00, 0, 2, 1, 1);
    xfer(1, 32'h3000_0010, 3'd2, 32'h1111_2222, AXI_RESP_SLVERR,
         0, 0, 0, 1);
    xfer(0, 32'h3000_0014, 3'd2, 32'h3333_4444, AXI_RESP_DECERR,
         0, 0, 2, 1);
    xfer(0, 32'h3000_0018, 3'd2, 32'h5555_6666, AXI_RESP_EXOKAY,
         0, 0, 0, 1);
    xfer(1, 32'h3000_0020, 3'd3, 32'h7777_8888, 2'b00, 0, 0, 0, 1);
    xfer(1, 32'h3000_0022, 3'd2, 32'h9999_AAAA, 2'b00, 0, 0, 0, 1);
    xfer(0, 32'h3000_0021, 3'd1, 32'hBBBB_CCCC, 2'b00, 0, 0, 0, 1);

    // BUSY and unselected cycles: zero-wait OKAY, no AXI traffic
    bus.hsel = 1'b1;
    bus.htrans = HTRANS_BUSY;
    @(negedge aclk);
    chk("busy_ready", {30'h0, bus.hreadyout, bus.hresp}, 32'h2);
    @(posedge aclk); #1;
    bus.htrans = HTRANS_IDLE;
    @(negedge aclk);
    chk("idle_no_axi", {29'h0, bus.hreadyout,
        bus.awvalid | bus.wvalid, bus.arvalid}, 32'h4);
    @(posedge aclk); #1;
    bus.hsel = 1'b0;

    // reset pulse while waiting for read data
    xfer(0, 32'h4000_0010, 3'd2, 32'hCAFE_F00D, 2'b00, 0, 0, 10, 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("rdat_reached", 32'(bus.rready), 1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_ahb", {30'h0, bus.hreadyout, bus.hresp}, 32'h2);
    chk("mid_rst_hrdata", bus.hrdata, 0);
    chk("mid_rst_axi", {27'h0, bus.awvalid, bus.wvalid,
        bus.arvalid, bus.bready, bus.rready}, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    xfer(0, 32'h4000_0014, 3'd2, 32'h0BAD_CAFE, 2'b00, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      s = (k < 9) ? 3'(k % 3) : 3'd3;
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (s == 3'd0) ? a[1:0] :
                 (s == 3'd1) ? {a[1], 1'b0} : 2'b00;
      k = $urandom_range(0, 7);
      rs = (k < 5) ? 2'b00 : 2'(k - 4);
      xfer(1'($urandom_range(0, 1)), a, s, $urandom, rs,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), 1);
    end

    repeat (2) @(posedge aclk);
    chk("rsp_left", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
